parity_frame_sequencer: RTL and testbench

- Accepts a parallel data word over a valid/ready handshake.
- Serializes the word LSB-first, then appends a generated parity bit (odd or even, set by parameter).
- Sits between a word source and a 1-bit serial link, and sequences the team's parity generator across a frame.
- Supports a transmit-enable stall, so the link side can pace bit emission.

---
 rtl/parity_pkg.sv | 30 +++
 rtl/parity_calc.sv | 14 +
 rtl/parity_frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_parity_frame_sequencer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity frame sequencer: state encoding and parity helper.
// PARITY_STOP_BIT_EN adds the STOP state encoding.
package parity_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [ST_W-1:0] ST_DATA   = 2'd1;
    localparam logic [ST_W-1:0] ST_PARITY = 2'd2;
`ifdef PARITY_STOP_BIT_EN
    localparam logic [ST_W-1:0] ST_STOP   = 2'd3;
`endif

    typedef enum logic [ST_W-1:0] {
        StIdle   = ST_IDLE,
        StData   = ST_DATA,
`ifdef PARITY_STOP_BIT_EN
        StParity = ST_PARITY,
        StStop   = ST_STOP
`else
        StParity = ST_PARITY
`endif
    } state_e;

    // Zero-padding the word to 32 bits does not change its XOR reduction.
    function automatic logic parity_of(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: reduction XOR of the word, inverted for odd parity.
module parity_calc
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          ODD    = 1'b1
) (
    input  logic [DATA_W-1:0] data,
    output logic              parity
);

    assign parity = parity_of(32'(data), ODD);

endmodule

// File: rtl/parity_frame_sequencer.sv
// Serializes a handshaked word LSB-first and appends its parity bit.
// Build option PARITY_STOP_BIT_EN appends a stop bit (1) after the parity bit.
module parity_frame_sequencer
    import parity_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter bit          ODD    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              tx_en,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              frame_start,
    output logic              frame_end,
    output logic              busy,
    output logic              parity_out
);

    localparam int unsigned     CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              parity_q, parity_d;
    logic              calc_parity;

    parity_calc #(
        .DATA_W (DATA_W),
        .ODD    (ODD)
    ) u_parity_calc (
        .data   (in_data),
        .parity (calc_parity)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            shift_q  <= '0;
            cnt_q    <= '0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        parity_d = parity_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shift_d  = in_data;
                    parity_d = calc_parity;
                    cnt_d    = '0;
                    state_d  = StData;
                end
            end
            StData: begin
                if (tx_en) begin
                    shift_d = shift_q >> 1;
                    // Counter parks on the last index rather than wrapping.
                    if (cnt_q == CNT_LAST) begin
                        state_d = StParity;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StParity: begin
                if (tx_en) begin
`ifdef PARITY_STOP_BIT_EN
                    state_d = StStop;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef PARITY_STOP_BIT_EN
            StStop: begin
                if (tx_en) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode registered state only; tx_en merely gates the strobes.
    always_comb begin
        in_ready    = 1'b0;
        busy        = 1'b1;
        ser_out     = 1'b0;
        ser_valid   = 1'b0;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            StData: begin
                ser_out     = shift_q[0];
                ser_valid   = tx_en;
                frame_start = tx_en && (cnt_q == '0);
            end
            StParity: begin
                ser_out   = parity_q;
                ser_valid = tx_en;
`ifndef PARITY_STOP_BIT_EN
                frame_end = tx_en;
`endif
            end
`ifdef PARITY_STOP_BIT_EN
            StStop: begin
                ser_out   = 1'b1;
                ser_valid = tx_en;
                frame_end = tx_en;
            end
`endif
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    assign parity_out = parity_q;

endmodule

// File: tb/tb_parity_frame_sequencer.sv
// Bench for parity_frame_sequencer: odd and even instances share stimulus and are
// checked every cycle against a queue-based frame model plus directed literal checks.
module tb_parity_frame_sequencer;

    localparam int unsigned DATA_W = 8;
`ifdef PARITY_STOP_BIT_EN
    localparam int FRAME_LEN = DATA_W + 2;
`else
    localparam int FRAME_LEN = DATA_W + 1;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       tx_en;

    logic in_ready1, ser_out1, ser_valid1, frame_start1, frame_end1, busy1, parity_out1;
    logic in_ready0, ser_out0, ser_valid0, frame_start0, frame_end0, busy0, parity_out0;

    int n_tests;
    int n_fail;
    int cyc;
    bit model_en;

    bit   q1[$];
    bit   q0[$];
    logic par1_exp;
    logic par0_exp;
    int   dut_accepts[$];

    parity_frame_sequencer #(
        .DATA_W (DATA_W),
        .ODD    (1'b1)
    ) u_odd (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready1),
        .tx_en       (tx_en),
        .ser_out     (ser_out1),
        .ser_valid   (ser_valid1),
        .frame_start (frame_start1),
        .frame_end   (frame_end1),
        .busy        (busy1),
        .parity_out  (parity_out1)
    );

    parity_frame_sequencer #(
        .DATA_W (DATA_W),
        .ODD    (1'b0)
    ) u_even (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready0),
        .tx_en       (tx_en),
        .ser_out     (ser_out0),
        .ser_valid   (ser_valid0),
        .frame_start (frame_start0),
        .frame_end   (frame_end0),
        .busy        (busy0),
        .parity_out  (parity_out0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame model: each accepted word becomes a queue of the bits still to be sent.
    always @(posedge clk) begin
        int ones;
        cyc++;
        if (rst) begin
            q1.delete();
            q0.delete();
            par1_exp = 1'b0;
            par0_exp = 1'b0;
        end else if (q1.size() != 0) begin
            if (tx_en) begin
                void'(q1.pop_front());
                void'(q0.pop_front());
            end
        end else if (in_valid) begin
            ones     = $countones(in_data);
            par0_exp = (ones % 2) == 1;
            par1_exp = (ones % 2) == 0;
            for (int i = 0; i < DATA_W; i++) begin
                q1.push_back(in_data[i]);
                q0.push_back(in_data[i]);
            end
            q1.push_back(par1_exp);
            q0.push_back(par0_exp);
`ifdef PARITY_STOP_BIT_EN
            q1.push_back(1'b1);
            q0.push_back(1'b1);
`endif
        end
    end

    always @(negedge clk) begin
        if (!rst && in_valid && in_ready1) dut_accepts.push_back(cyc);
    end

    always @(negedge clk) begin
        logic       busy_e;
        logic [6:0] exp1, exp0, act1, act0;
        if (model_en) begin
            busy_e = q1.size() != 0;
            exp1 = {!busy_e, busy_e, busy_e && tx_en, busy_e ? q1[0] : 1'b0,
                    busy_e && tx_en && q1.size() == FRAME_LEN,
                    busy_e && tx_en && q1.size() == 1, par1_exp};
            exp0 = {!busy_e, busy_e, busy_e && tx_en, busy_e ? q0[0] : 1'b0,
                    busy_e && tx_en && q0.size() == FRAME_LEN,
                    busy_e && tx_en && q0.size() == 1, par0_exp};
            act1 = {in_ready1, busy1, ser_valid1, ser_out1, frame_start1, frame_end1, parity_out1};
            act0 = {in_ready0, busy0, ser_valid0, ser_out0, frame_start0, frame_end0, parity_out0};
            check("odd_outputs", 32'(act1), 32'(exp1));
            check("even_outputs", 32'(act0), 32'(exp0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int g;
        in_data  = d;
        in_valid = 1'b1;
        g = 0;
        while (!in_ready1 && g < 50) begin
            tick();
            g++;
        end
        check("send_ready", 32'(in_ready1), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while (busy1 && g < 50) begin
            tick();
            g++;
        end
        check("wait_idle", 32'(busy1), 32'd0);
    endtask

    initial begin
        logic [9:0] seq;
        logic [9:0] seq_exp;
        int         g;
        int         spacing_exp;
        n_tests  = 0;
        n_fail   = 0;
        cyc      = 0;
        model_en = 1'b0;
        rst      = 1'b1;
        tx_en    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        model_en = 1'b1;
        check("reset_in_ready", 32'(in_ready1), 32'd1);
        check("reset_busy", 32'(busy1), 32'd0);
        check("reset_ser", 32'({ser_out1, ser_valid1, frame_start1, frame_end1}), 32'd0);
        check("reset_parity", 32'(parity_out1), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // 8'hA5 odd parity: bits 1,0,1,0,0,1,0,1 then parity 1.
        send(8'hA5);
        seq = '0;
        for (int i = 0; i < FRAME_LEN; i++) begin
            seq[i] = ser_out1;
            check("a5_frame_start", 32'(frame_start1), 32'(i == 0));
            check("a5_frame_end", 32'(frame_end1), 32'(i == FRAME_LEN - 1));
            tick();
        end
`ifdef PARITY_STOP_BIT_EN
        seq_exp = 10'b11_1010_0101;
`else
        seq_exp = 10'b01_1010_0101;
`endif
        check("a5_sequence", 32'(seq), 32'(seq_exp));
        check("a5_ready_after", 32'(in_ready1), 32'd1);
        check("a5_even_parity", 32'(parity_out0), 32'd0);

        send(8'h07);
        check("h07_odd_parity", 32'(parity_out1), 32'd0);
        check("h07_even_parity", 32'(parity_out0), 32'd1);
        wait_idle();
        send(8'h00);
        check("h00_even_parity", 32'(parity_out0), 32'd0);
        check("h00_odd_parity", 32'(parity_out1), 32'd1);
        wait_idle();

        // Stall on bit index 3 of 8'h3C for two cycles.
        send(8'h3C);
        repeat (3) tick();
        tx_en = 1'b0;
        #1;
        check("stall1_ser_out", 32'(ser_out1), 32'd1);
        check("stall1_valid", 32'(ser_valid1), 32'd0);
        tick();
        check("stall2_ser_out", 32'(ser_out1), 32'd1);
        check("stall2_valid", 32'(ser_valid1), 32'd0);
        tick();
        tx_en = 1'b1;
        #1;
        check("resume_bit3", 32'({ser_valid1, ser_out1}), 32'b11);
        wait_idle();

        // Reset during data bit 4 of 8'hFF.
        send(8'hFF);
        repeat (4) tick();
        check("ff_parity_before_rst", 32'(parity_out1), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_mid_busy", 32'(busy1), 32'd0);
        check("rst_mid_ready", 32'(in_ready1), 32'd1);
        check("rst_mid_valid", 32'(ser_valid1), 32'd0);
        check("rst_mid_parity", 32'(parity_out1), 32'd0);
        send(8'h01);
        check("h01_odd_parity", 32'(parity_out1), 32'd0);
        wait_idle();

        // Back-to-back with in_valid held and in_data switched while busy.
        tick();
        dut_accepts.delete();
        in_data  = 8'h11;
        in_valid = 1'b1;
        tick();
        in_data = 8'h22;
        g = 0;
        while (dut_accepts.size() < 2 && g < 40) begin
            tick();
            g++;
        end
        in_valid = 1'b0;
        in_data  = 8'hFF;
`ifdef PARITY_STOP_BIT_EN
        spacing_exp = 11;
`else
        spacing_exp = 10;
`endif
        if (dut_accepts.size() >= 2) begin
            check("b2b_spacing", 32'(dut_accepts[1] - dut_accepts[0]), 32'(spacing_exp));
        end else begin
            check("b2b_accepts", 32'(dut_accepts.size()), 32'd2);
        end
        wait_idle();

        // Randomized traffic, stalls and occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_data  = 8'($urandom);
            tx_en    = ($urandom_range(0, 3) != 0);
            tick();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        tx_en    = 1'b1;
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
